// File: rtl/mover_pkg.sv
// Shared state encoding and width defaults for the RAM block mover.
package mover_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        READ   = ST_READ,
        WRITE  = ST_WRITE,
        FINISH = ST_FINISH
    } state_t;

endpackage

// File: rtl/ram_addr_stepper.sv
// Loadable RAM word pointer that steps up or down by one,
// wrapping naturally at the address width.
module ram_addr_stepper
    import mover_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_value;
        end else if (step) begin
            ptr <= down ? ptr - ADDR_W'(1) : ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ram_block_mover.sv
// Overlap-safe block copy engine for the data RAM.
// Define MOVER_FILL_EN to add a constant-fill mode (fill, fill_value).
module ram_block_mover
    import mover_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   count,
`ifdef MOVER_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_in,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_out
);

    state_t              state;
    logic [DATA_W-1:0]   data_reg;
    logic [ADDR_W:0]     remaining;
    logic                down;
    logic                fill_mode;

    logic                fill_req;
    logic [DATA_W-1:0]   fill_data;
    logic                desc_req;
    logic                start_go;
    logic                step;
    logic [ADDR_W-1:0]   span;
    logic [ADDR_W-1:0]   src_start;
    logic [ADDR_W-1:0]   dst_start;
    logic [ADDR_W-1:0]   src_ptr;
    logic [ADDR_W-1:0]   dst_ptr;

`ifdef MOVER_FILL_EN
    assign fill_req  = fill;
    assign fill_data = fill_value;
`else
    assign fill_req  = 1'b0;
    assign fill_data = '0;
`endif

    // Copying toward higher addresses runs backwards so no source word
    // is overwritten before it is read.
    assign desc_req  = !fill_req && (dst_addr > src_addr);
    assign span      = count[ADDR_W-1:0] - ADDR_W'(1);
    assign src_start = desc_req ? src_addr + span : src_addr;
    assign dst_start = desc_req ? dst_addr + span : dst_addr;
    assign start_go  = (state == IDLE) && start;
    assign step      = (state == WRITE);

    ram_addr_stepper #(.ADDR_W(ADDR_W)) u_src (
        .clk        (clk),
        .reset      (reset),
        .load       (start_go),
        .load_value (src_start),
        .step       (step),
        .down       (down),
        .ptr        (src_ptr)
    );

    ram_addr_stepper #(.ADDR_W(ADDR_W)) u_dst (
        .clk        (clk),
        .reset      (reset),
        .load       (start_go),
        .load_value (dst_start),
        .step       (step),
        .down       (down),
        .ptr        (dst_ptr)
    );

    assign mem_address = (state == WRITE) ? dst_ptr : src_ptr;
    assign mem_in      = data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_load  <= 1'b0;
            data_reg  <= '0;
            remaining <= '0;
            down      <= 1'b0;
            fill_mode <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= count;
                        down      <= desc_req;
                        fill_mode <= fill_req;
                        if (count == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (fill_req) begin
                            state    <= WRITE;
                            busy     <= 1'b1;
                            mem_load <= 1'b1;
                            data_reg <= fill_data;
                        end else begin
                            state <= READ;
                            busy  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    data_reg <= mem_out;
                    mem_load <= 1'b1;
                    state    <= WRITE;
                end
                WRITE: begin
                    remaining <= remaining - (ADDR_W+1)'(1);
                    if (remaining == (ADDR_W+1)'(1)) begin
                        state    <= FINISH;
                        busy     <= 1'b0;
                        mem_load <= 1'b0;
                        done     <= 1'b1;
                    end else if (!fill_mode) begin
                        state    <= READ;
                        mem_load <= 1'b0;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_block_mover.sv
// Bench pairing the mover with a 16K x 16 RAM model and an
// element-by-element reference of each transfer.
module tb_ram_block_mover;

    localparam int N = 16384;

    logic        clk;
    logic        reset;
    logic        start;
    logic [13:0] src_addr;
    logic [13:0] dst_addr;
    logic [14:0] count;
    logic        fill;
    logic [15:0] fill_value;
    logic        busy;
    logic        done;
    logic [13:0] mem_address;
    logic [15:0] mem_in;
    logic        mem_load;
    logic [15:0] mem_out;

    logic [15:0] mem     [0:N-1];
    logic [15:0] ref_mem [0:N-1];

    logic        tb_we;
    logic [13:0] tb_addr;
    logic [15:0] tb_data;

    int checks = 0;
    int passed = 0;

    ram_block_mover dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .count       (count),
`ifdef MOVER_FILL_EN
        .fill        (fill),
        .fill_value  (fill_value),
`endif
        .busy        (busy),
        .done        (done),
        .mem_address (mem_address),
        .mem_in      (mem_in),
        .mem_load    (mem_load),
        .mem_out     (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_out = mem[mem_address];

    always @(posedge clk) begin
        if (mem_load)
            mem[mem_address] <= mem_in;
        else if (tb_we)
            mem[tb_addr] <= tb_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic poke(input int a, input logic [15:0] v);
        tb_addr = a[13:0];
        tb_data = v;
        tb_we   = 1'b1;
        @(negedge clk);
        tb_we   = 1'b0;
    endtask

    // Reference: words move one at a time, highest first when the
    // destination lies above the source, otherwise lowest first.
    task automatic model(input int s, input int d, input int c,
                         input bit f, input logic [15:0] fv);
        ref_mem = mem;
        if (f) begin
            for (int i = 0; i < c; i++) ref_mem[(d + i) % N] = fv;
        end else if (d > s) begin
            for (int i = c - 1; i >= 0; i--)
                ref_mem[(d + i) % N] = ref_mem[(s + i) % N];
        end else begin
            for (int i = 0; i < c; i++)
                ref_mem[(d + i) % N] = ref_mem[(s + i) % N];
        end
    endtask

    task automatic mem_check(input string tag);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        if (bad != 0)
            $display("note %s: first differing word at %0d", tag, first);
        chk({tag, ".mem_diffs"}, bad, 0);
    endtask

    task automatic xfer(input string tag, input int s, input int d,
                        input int c, input bit f, input logic [15:0] fv,
                        input bit retrig);
        int bc;
        int dc;
        int done_at;
        int bad_load;
        int exp_busy;
        model(s, d, c, f, fv);
        exp_busy = f ? c : 2 * c;
        @(negedge clk);
        src_addr   = s[13:0];
        dst_addr   = d[13:0];
        count      = c[14:0];
        fill       = f;
        fill_value = fv;
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        src_addr = 14'($urandom);
        dst_addr = 14'($urandom);
        count    = 15'($urandom);
        fill     = ~f;
        bc = 0;
        dc = 0;
        done_at = -1;
        bad_load = 0;
        for (int k = 0; k < exp_busy + 8; k++) begin
            if (busy) bc++;
            if (done) begin
                dc++;
                if (done_at < 0) done_at = k;
            end
            if (mem_load && !busy) bad_load++;
            start = retrig && (k == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, ".busy_cycles"}, bc, exp_busy);
        chk({tag, ".done_pulses"}, dc, 1);
        chk({tag, ".done_at"}, done_at, exp_busy);
        chk({tag, ".load_outside_busy"}, bad_load, 0);
        mem_check(tag);
    endtask

    initial begin
        int s;
        int d;
        int c;
        int k;
        int dseen;
        reset      = 1'b1;
        start      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        count      = '0;
        fill       = 1'b0;
        fill_value = '0;
        tb_we      = 1'b0;
        tb_addr    = '0;
        tb_data    = '0;
        #1;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.mem_load", mem_load, 0);
        chk("reset.mem_address", mem_address, 0);
        chk("reset.mem_in", mem_in, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < N; i++) poke(i, 16'($urandom));

        poke(100, 16'hA0A0);
        poke(101, 16'hB1B1);
        poke(102, 16'hC2C2);
        poke(103, 16'hD3D3);
        xfer("asc", 100, 200, 4, 1'b0, 16'h0, 1'b0);
        chk("asc.w200", mem[200], 16'hA0A0);
        chk("asc.w201", mem[201], 16'hB1B1);
        chk("asc.w202", mem[202], 16'hC2C2);
        chk("asc.w203", mem[203], 16'hD3D3);

        for (int i = 0; i < 5; i++) poke(10 + i, 16'(i + 1));
        xfer("overlap", 10, 12, 5, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 5; i++)
            chk($sformatf("overlap.w%0d", 12 + i), mem[12 + i], i + 1);
        chk("overlap.w10", mem[10], 1);
        chk("overlap.w11", mem[11], 2);

        poke(16382, 16'h1111);
        poke(16383, 16'h2222);
        poke(0, 16'h3333);
        xfer("wrap_src", 16382, 5, 3, 1'b0, 16'h0, 1'b0);
        chk("wrap_src.w5", mem[5], 16'h1111);
        chk("wrap_src.w6", mem[6], 16'h2222);
        chk("wrap_src.w7", mem[7], 16'h3333);
        xfer("wrap_dst", 5, 16382, 3, 1'b0, 16'h0, 1'b0);
        chk("wrap_dst.w0", mem[0], 16'h3333);

        xfer("count0", 300, 400, 0, 1'b0, 16'h0, 1'b0);
        xfer("same", 700, 700, 6, 1'b0, 16'h0, 1'b0);
        xfer("retrig", 900, 950, 4, 1'b0, 16'h0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            s = $urandom_range(16, 16000);
            if ($urandom_range(0, 1) == 1)
                d = s + $urandom_range(0, 8) - 4;
            else
                d = $urandom_range(0, 16000);
            c = $urandom_range(1, 40);
            xfer($sformatf("rand%0d", r), s, d, c, 1'b0, 16'h0, 1'b0);
        end

`ifdef MOVER_FILL_EN
        xfer("fill", 1234, 50, 4, 1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("fill.w%0d", 50 + i), mem[50 + i], 16'hBEEF);
`endif

        @(negedge clk);
        src_addr = 14'd1000;
        dst_addr = 14'd2000;
        count    = 15'd20;
        fill     = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!mem_load && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid.in_write", mem_load, 1);
        #1;
        reset = 1'b1;
        #1;
        chk("rst_mid.mem_load", mem_load, 0);
        chk("rst_mid.busy", busy, 0);
        chk("rst_mid.done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        dseen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dseen++;
            @(negedge clk);
        end
        chk("rst_mid.quiet_after", dseen, 0);

        xfer("full", 0, 3, N, 1'b0, 16'h0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
